// File: rtl/usb_rx_pkg.sv
// Purpose : shared receive-side USB types (line states, EOP FSM states, counter width).
// Latency : n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   line_state_t - decoded differential pair state
//   eop_state_t  - EOP detector FSM states
//   CNT_W        - width of the EOP detector sample counter
package usb_rx_pkg;

   localparam int CNT_W = 8;

   typedef enum logic [1:0] {
      LS_SE0 = 2'd0,
      LS_J   = 2'd1,
      LS_K   = 2'd2,
      LS_SE1 = 2'd3
   } line_state_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SE0_CNT = 2'd1,
      J_CHK   = 2'd2
   } eop_state_t;

endpackage

// File: rtl/eop_detector_if.sv
// Purpose : bundle of line-side inputs and event outputs of the EOP detector.
// Latency : n/a (wiring only).
// Backpressure: none; the receive line is free-running.
//
// Signals:
//   enable        receiver active (0 forces the detector to IDLE)
//   d_plus/d_minus synchronized differential pair
//   eop_detected  one-cycle pulse, valid EOP
//   eop_error     one-cycle pulse, malformed EOP
//   se0_active    level, detector is counting SE0
//   usb_reset     level, bus reset seen (tied 0 without BUS_RESET_DETECT_EN)
// Modports: master = line/control side, slave = detector side.
interface eop_detector_if;

   logic enable;
   logic d_plus;
   logic d_minus;
   logic eop_detected;
   logic eop_error;
   logic se0_active;
   logic usb_reset;

   modport master (
      output enable, d_plus, d_minus,
      input  eop_detected, eop_error, se0_active, usb_reset
   );

   modport slave (
      input  enable, d_plus, d_minus,
      output eop_detected, eop_error, se0_active, usb_reset
   );

endinterface

// File: rtl/line_state_decode.sv
// Purpose : map the synchronized D+/D- pair onto a line_state_t.
// Latency : combinational, zero cycles.
// Backpressure: none.
//
// Ports:
//   i_d_plus, i_d_minus  synchronized differential pair
//   o_line_state         SE0 (0,0), J (1,0), K (0,1), SE1 (1,1)
module line_state_decode
   import usb_rx_pkg::*;
(
   input  logic        i_d_plus,
   input  logic        i_d_minus,
   output line_state_t o_line_state
);

   always_comb begin
      o_line_state = LS_SE0;
      case ({i_d_plus, i_d_minus})
         2'b00:   o_line_state = LS_SE0;
         2'b10:   o_line_state = LS_J;
         2'b01:   o_line_state = LS_K;
         default: o_line_state = LS_SE1;
      endcase
   end

endmodule

// File: rtl/eop_detector.sv
// Purpose : detect USB End-Of-Packet (SE0 ~2 bit times, then J for 1 bit time) on the receive pair.
// Latency : eop_detected/eop_error pulse in the cycle after the deciding sample; all outputs registered.
// Backpressure: none; one sample is consumed every clock.
//
// Ports:
//   clk   system clock, rising edge
//   rst   synchronous active-high reset
//   bus   eop_detector_if.slave (enable, d_plus, d_minus in; eop_detected, eop_error,
//         se0_active, usb_reset out)
// Optional feature macro: BUS_RESET_DETECT_EN -- when defined, an SE0 lasting RESET_CLKS
// samples raises usb_reset instead of ending in eop_error.
module eop_detector
   import usb_rx_pkg::*;
#(
   parameter int SE0_MIN_CLKS = 12,
   parameter int SE0_MAX_CLKS = 20,
   parameter int J_CLKS       = 8,
   parameter int RESET_CLKS   = 64
)
(
   input  logic           clk,
   input  logic           rst,
   eop_detector_if.slave  bus
);

   if (!((SE0_MIN_CLKS <= SE0_MAX_CLKS) && (SE0_MAX_CLKS < RESET_CLKS) &&
         (RESET_CLKS <= 255) && (J_CLKS >= 2) && (J_CLKS <= 255))) begin : g_bad_params
      $error("eop_detector: illegal parameter combination");
   end

   localparam logic [CNT_W-1:0] C_SE0_MIN = CNT_W'(SE0_MIN_CLKS);
   localparam logic [CNT_W-1:0] C_SE0_MAX = CNT_W'(SE0_MAX_CLKS);
   localparam logic [CNT_W-1:0] C_J_LAST  = CNT_W'(J_CLKS - 1);
   localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

   line_state_t       w_ls;
   eop_state_t        r_state;
   eop_state_t        w_state_nxt;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic [CNT_W-1:0]  w_cnt_inc;
   logic              w_det_nxt;
   logic              w_err_nxt;
   logic              w_in_bus_reset;
   logic              r_eop_detected;
   logic              r_eop_error;
   logic              r_se0_active;

   line_state_decode u_decode (
      .i_d_plus     (bus.d_plus),
      .i_d_minus    (bus.d_minus),
      .o_line_state (w_ls)
   );

   // Saturating increment so an arbitrarily long SE0 cannot wrap back into the valid window.
   assign w_cnt_inc = (r_cnt == C_CNT_MAX) ? r_cnt : r_cnt + 1'b1;

`ifdef BUS_RESET_DETECT_EN
   localparam logic [CNT_W-1:0] C_RESET = CNT_W'(RESET_CLKS);
   logic r_usb_reset;
   logic w_usb_reset_nxt;

   // Once set, usb_reset stays up exactly as long as the FSM keeps counting SE0.
   assign w_usb_reset_nxt = (w_state_nxt == SE0_CNT) &&
                            (r_usb_reset || (w_cnt_nxt >= C_RESET));
   assign w_in_bus_reset  = r_usb_reset;
   assign bus.usb_reset   = r_usb_reset;
`else
   assign w_in_bus_reset  = 1'b0;
   assign bus.usb_reset   = 1'b0;
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_det_nxt   = 1'b0;
      w_err_nxt   = 1'b0;
      if (!bus.enable) begin
         w_state_nxt = IDLE;
         w_cnt_nxt   = '0;
      end else begin
         case (r_state)
            IDLE: begin
               // SE1 and K are line noise here; only SE0 can open an EOP.
               if (w_ls == LS_SE0) begin
                  w_state_nxt = SE0_CNT;
                  w_cnt_nxt   = CNT_W'(1);
               end
            end
            SE0_CNT: begin
               case (w_ls)
                  LS_SE0: w_cnt_nxt = w_cnt_inc;
                  LS_J: begin
                     w_state_nxt = IDLE;
                     w_cnt_nxt   = '0;
                     if (w_in_bus_reset) begin
                        // End of a bus reset is not a malformed EOP.
                     end else if ((r_cnt >= C_SE0_MIN) && (r_cnt <= C_SE0_MAX)) begin
                        w_state_nxt = J_CHK;
                        w_cnt_nxt   = CNT_W'(1);
                     end else begin
                        w_err_nxt   = 1'b1;
                     end
                  end
                  default: begin
                     w_state_nxt = IDLE;
                     w_cnt_nxt   = '0;
                     w_err_nxt   = !w_in_bus_reset;
                  end
               endcase
            end
            J_CHK: begin
               if (w_ls == LS_J) begin
                  if (r_cnt == C_J_LAST) begin
                     w_state_nxt = IDLE;
                     w_cnt_nxt   = '0;
                     w_det_nxt   = 1'b1;
                  end else begin
                     w_cnt_nxt   = w_cnt_inc;
                  end
               end else begin
                  // Includes SE0: the sample is spent on the error, not on a new EOP.
                  w_state_nxt = IDLE;
                  w_cnt_nxt   = '0;
                  w_err_nxt   = 1'b1;
               end
            end
            default: begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= IDLE;
         r_cnt          <= '0;
         r_eop_detected <= 1'b0;
         r_eop_error    <= 1'b0;
         r_se0_active   <= 1'b0;
      end else begin
         r_state        <= w_state_nxt;
         r_cnt          <= w_cnt_nxt;
         r_eop_detected <= w_det_nxt;
         r_eop_error    <= w_err_nxt;
         r_se0_active   <= (w_state_nxt == SE0_CNT);
      end
   end

`ifdef BUS_RESET_DETECT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         r_usb_reset <= 1'b0;
      end else begin
         r_usb_reset <= w_usb_reset_nxt;
      end
   end
`endif

   assign bus.eop_detected = r_eop_detected;
   assign bus.eop_error    = r_eop_error;
   assign bus.se0_active   = r_se0_active;

endmodule
